// File: rtl/card_dealer_if.sv
// -----------------------------------------------------------------------------
// card_dealer_if
// Deal/shuffle request and card result bundle for the card dealer.
//   i_deal        requester -> dealer  deal one card (sampled on clock edge)
//   i_shuffle     requester -> dealer  restore full 52-card deck
//   o_card_valid  dealer -> requester  one-cycle pulse, card fields valid
//   o_card        dealer -> requester  point value (A=1, 2..10, J/Q/K=10)
//   o_rank        dealer -> requester  rank 1..13 (A..K)
//   o_suit        dealer -> requester  suit 0..3
//   o_busy        dealer -> requester  dealer not idle
//   o_cards_left  dealer -> requester  undealt cards, 0..52
//   o_error       dealer -> requester  one-cycle pulse, deal on empty deck
// master = requester side, slave = dealer side.
// -----------------------------------------------------------------------------
interface card_dealer_if;
    logic       i_deal;
    logic       i_shuffle;
    logic       o_card_valid;
    logic [4:0] o_card;
    logic [3:0] o_rank;
    logic [1:0] o_suit;
    logic       o_busy;
    logic [5:0] o_cards_left;
    logic       o_error;

    modport master (
        output i_deal, i_shuffle,
        input  o_card_valid, o_card, o_rank, o_suit, o_busy, o_cards_left, o_error
    );

    modport slave (
        input  i_deal, i_shuffle,
        output o_card_valid, o_card, o_rank, o_suit, o_busy, o_cards_left, o_error
    );
endinterface

// File: rtl/card_dealer.sv
// -----------------------------------------------------------------------------
// card_dealer
// Deals cards from a single 52-card deck without repetition. A free-running
// LFSR picks a starting deck index; a linear probe walks forward (wrapping)
// to the first undealt index, which is then marked dealt and presented.
// Deck index k decodes to suit = k/13, rank = (k mod 13)+1.
// Ports:
//   i_clk    rising-edge clock
//   i_reset  asynchronous, active-high reset
//   bus      card_dealer_if.slave (deal/shuffle in, card/status out)
// Parameter:
//   SEED     LFSR reset value, must be nonzero
// -----------------------------------------------------------------------------
module card_dealer #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    card_dealer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SEARCH, EMIT} state_t;

    localparam logic [5:0] DECK_SIZE = 6'd52;
    localparam logic [5:0] LAST_IDX  = 6'd51;

    state_t      state_q,      state_d;
    logic [51:0] mask_q,       mask_d;
    logic [5:0]  left_q,       left_d;
    logic [15:0] lfsr_q,       lfsr_d;
    logic [5:0]  probe_q,      probe_d;
    logic        card_valid_q, card_valid_d;
    logic        error_q,      error_d;
    logic [4:0]  card_q,       card_d;
    logic [3:0]  rank_q,       rank_d;
    logic [1:0]  suit_q,       suit_d;

    // Decoded view of the current probe index.
    logic [1:0]  dec_suit;
    logic [3:0]  dec_rank;
    logic [4:0]  dec_card;

    always_comb begin
        dec_suit = 2'd0;
        dec_rank = 4'd1;
        if (probe_q < 6'd13) begin
            dec_suit = 2'd0;
            dec_rank = probe_q[3:0] + 4'd1;
        end else if (probe_q < 6'd26) begin
            dec_suit = 2'd1;
            dec_rank = 4'(probe_q - 6'd13) + 4'd1;
        end else if (probe_q < 6'd39) begin
            dec_suit = 2'd2;
            dec_rank = 4'(probe_q - 6'd26) + 4'd1;
        end else begin
            dec_suit = 2'd3;
            dec_rank = 4'(probe_q - 6'd39) + 4'd1;
        end
        dec_card = (dec_rank > 4'd10) ? 5'd10 : {1'b0, dec_rank};
    end

    always_comb begin
        // NOTE: every _d gets a default up front so no path leaves it
        // unassigned; a missing default in always_comb infers a latch.
        state_d      = state_q;
        mask_d       = mask_q;
        left_d       = left_q;
        probe_d      = probe_q;
        card_d       = card_q;
        rank_d       = rank_q;
        suit_d       = suit_q;
        card_valid_d = 1'b0;
        error_d      = 1'b0;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        unique case (state_q)
            IDLE: begin
                if (bus.i_deal) begin
                    if (left_q != 6'd0) begin
                        // Fold the 0..63 LFSR slice into 0..51.
                        probe_d = (lfsr_q[5:0] >= DECK_SIZE) ? lfsr_q[5:0] - DECK_SIZE
                                                             : lfsr_q[5:0];
                        state_d = SEARCH;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            SEARCH: begin
                // At least one bit is clear whenever we are here, so the
                // probe terminates within 52 steps.
                if (!mask_q[probe_q]) begin
                    state_d = EMIT;
                end else begin
                    probe_d = (probe_q == LAST_IDX) ? 6'd0 : probe_q + 6'd1;
                end
            end
            EMIT: begin
                mask_d[probe_q] = 1'b1;
                left_d          = left_q - 6'd1;
                card_valid_d    = 1'b1;
                card_d          = dec_card;
                rank_d          = dec_rank;
                suit_d          = dec_suit;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Shuffle overrides everything, including a deal in flight; the
        // last dealt card stays on the outputs and the LFSR keeps running.
        if (bus.i_shuffle) begin
            state_d      = IDLE;
            mask_d       = '0;
            left_d       = DECK_SIZE;
            card_valid_d = 1'b0;
            error_d      = 1'b0;
            card_d       = card_q;
            rank_d       = rank_q;
            suit_d       = suit_q;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            // NOTE: the dealt mask is plain flops, not a RAM, so it is
            // reset directly; a full deck must be available right after reset.
            mask_q       <= '0;
            left_q       <= DECK_SIZE;
            lfsr_q       <= SEED;
            probe_q      <= 6'd0;
            card_valid_q <= 1'b0;
            error_q      <= 1'b0;
            card_q       <= 5'd0;
            rank_q       <= 4'd0;
            suit_q       <= 2'd0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            left_q       <= left_d;
            lfsr_q       <= lfsr_d;
            probe_q      <= probe_d;
            card_valid_q <= card_valid_d;
            error_q      <= error_d;
            card_q       <= card_d;
            rank_q       <= rank_d;
            suit_q       <= suit_d;
        end
    end

    assign bus.o_card_valid = card_valid_q;
    assign bus.o_card       = card_q;
    assign bus.o_rank       = rank_q;
    assign bus.o_suit       = suit_q;
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_cards_left = left_q;
    assign bus.o_error      = error_q;

endmodule

// File: tb/tb_card_dealer.sv
// -----------------------------------------------------------------------------
// tb_card_dealer
// Scoreboard bench for card_dealer. A reference LFSR plus a deck mask
// predict which index each deal must produce; predictions are queued by the
// driver and popped by an independent monitor on every o_card_valid pulse.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_card_dealer;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int suit;
        int rank;
        int card;
        int left;
        int acc;
        int lat;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_reset;

    card_dealer_if bus ();

    card_dealer #(.SEED(SEED)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          err_pending = 0;
    exp_t        sb[$];
    logic [51:0] m_mask;
    logic [51:0] seen;
    int          m_left;
    logic [15:0] m_lfsr;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Reference LFSR: taps 15,13,12,10, one step per clock.
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) m_lfsr <= SEED;
        else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: card pulses against the scoreboard, error pulses against
    // the count of outstanding empty-deck requests.
    always @(negedge i_clk) begin
        if (bus.o_card_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_card_valid", 0, 1);
            end else begin
                exp_t e;
                int   idx;
                e = sb.pop_front();
                check("suit",       bus.o_suit,       e.suit);
                check("rank",       bus.o_rank,       e.rank);
                check("card_value", bus.o_card,       e.card);
                check("cards_left", bus.o_cards_left, e.left);
                check("latency",    cyc - e.acc,      e.lat);
                if (bus.o_rank >= 1 && bus.o_rank <= 13) begin
                    idx = int'(bus.o_suit) * 13 + int'(bus.o_rank) - 1;
                    check("distinct", seen[idx], 0);
                    seen[idx] = 1'b1;
                end
            end
        end
        if (bus.o_error === 1'b1) begin
            check("error_expected", (err_pending > 0) ? 1 : 0, 1);
            if (err_pending > 0) err_pending--;
        end
    end

    // Deal one card from a non-empty deck; called and returns on a falling edge.
    task automatic deal_card();
        exp_t e;
        int   probe;
        int   steps;
        probe = int'(m_lfsr[5:0]);
        if (probe >= 52) probe -= 52;
        steps = 0;
        while (m_mask[probe]) begin
            probe = (probe == 51) ? 0 : probe + 1;
            steps++;
        end
        m_mask[probe] = 1'b1;
        m_left--;
        e.suit = probe / 13;
        e.rank = probe % 13 + 1;
        e.card = (e.rank > 10) ? 10 : e.rank;
        e.left = m_left;
        e.acc  = cyc + 1;
        e.lat  = 2 + steps;
        sb.push_back(e);
        bus.i_deal = 1'b1;
        @(negedge i_clk);
        bus.i_deal = 1'b0;
        check("busy_after_accept", bus.o_busy, 1);
        for (int i = 0; i < 60; i++) begin
            if (!bus.o_busy) break;
            @(negedge i_clk);
        end
        if (bus.o_busy) check("deal_timeout", 1, 0);
    endtask

    // Deal request on an empty deck.
    task automatic deal_empty();
        err_pending++;
        bus.i_deal = 1'b1;
        @(negedge i_clk);
        bus.i_deal = 1'b0;
        repeat (3) @(negedge i_clk);
        check("empty_cards_left", bus.o_cards_left, 0);
        check("empty_busy",       bus.o_busy,       0);
    endtask

    task automatic shuffle(input logic with_deal);
        bus.i_shuffle = 1'b1;
        bus.i_deal    = with_deal;
        @(negedge i_clk);
        bus.i_shuffle = 1'b0;
        bus.i_deal    = 1'b0;
        m_mask = '0;
        m_left = 52;
        seen   = '0;
        check("shuffle_cards_left", bus.o_cards_left, 52);
        check("shuffle_busy",       bus.o_busy,       0);
    endtask

    // Start a deal that will be aborted; no expectation is queued.
    task automatic start_raw_deal();
        bus.i_deal = 1'b1;
        @(negedge i_clk);
        bus.i_deal = 1'b0;
        check("raw_deal_busy", bus.o_busy, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cards_left"}, bus.o_cards_left, 52);
        check({tag, "_busy"},       bus.o_busy,       0);
        check({tag, "_card"},       bus.o_card,       0);
        check({tag, "_rank"},       bus.o_rank,       0);
        check({tag, "_suit"},       bus.o_suit,       0);
        check({tag, "_valid"},      bus.o_card_valid, 0);
        check({tag, "_error"},      bus.o_error,      0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.i_deal    = 1'b0;
        bus.i_shuffle = 1'b0;
        i_reset       = 1'b1;
        m_mask        = '0;
        seen          = '0;
        m_left        = 52;

        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_reset = 1'b0;

        // Full deck, first deal on the first edge after reset release.
        for (int i = 0; i < 52; i++) deal_card();
        check("deck_empty_cards_left", bus.o_cards_left, 0);

        deal_empty();

        // Partial deal, reshuffle, then a shuffle colliding with a deal.
        shuffle(1'b0);
        for (int i = 0; i < 10; i++) deal_card();
        check("ten_dealt_cards_left", bus.o_cards_left, 42);
        shuffle(1'b1);
        repeat (4) @(negedge i_clk);
        check("shuffle_deal_dropped_busy", bus.o_busy,       0);
        check("shuffle_deal_dropped_left", bus.o_cards_left, 52);
        for (int i = 0; i < 52; i++) deal_card();
        check("second_deck_cards_left", bus.o_cards_left, 0);

        // Shuffle aborting a deal in flight.
        shuffle(1'b0);
        start_raw_deal();
        shuffle(1'b0);
        repeat (4) @(negedge i_clk);
        check("abort_shuffle_busy", bus.o_busy, 0);
        deal_card();

        // Reset aborting a deal in flight.
        start_raw_deal();
        i_reset = 1'b1;
        m_mask  = '0;
        m_left  = 52;
        seen    = '0;
        #1;
        check_reset_outputs("midsearch_reset");
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (3) @(negedge i_clk);
        check("post_reset_busy", bus.o_busy, 0);
        deal_card();
        check("post_reset_cards_left", bus.o_cards_left, 51);

        repeat (5) @(negedge i_clk);
        check("scoreboard_drained", sb.size(),   0);
        check("errors_seen",        err_pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter SEED, default 16'hACE1, meaning LFSR reset value; SEED SHALL be nonzero.
REQ-002 SHALL have port i_clk  input  1  rising-edge system clock.
REQ-003 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_deal  input  1  deal request, sampled on clock edge.
REQ-005 SHALL have port i_shuffle  input  1  restore full 52-card deck.
REQ-006 SHALL have port o_card_valid  output  1  one-cycle pulse, card outputs valid; drives hand controller's add-card strobe.
REQ-007 SHALL have port o_card  output  5  point value: ace=1, 2..10 face value, J/Q/K=10.
REQ-008 SHALL have port o_rank  output  4  rank: 1=A, 2..10, 11=J, 12=Q, 13=K.
REQ-009 SHALL have port o_suit  output  2  suit: 0..3.
REQ-010 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port o_cards_left  output  6  undealt cards remaining, 0..52.
REQ-012 SHALL have port o_error  output  1  one-cycle pulse, deal requested with empty deck.

Function
REQ-013 SHALL hold a 52-bit dealt mask; bit k set means deck index k already dealt.
REQ-014 SHALL map index k to suit = k/13, rank = (k mod 13)+1.
REQ-015 SHALL run a 16-bit Fibonacci LFSR advancing every clock: shift left, new bit0 = b15^b13^b12^b10.
REQ-016 SHALL implement FSM states IDLE, SEARCH, EMIT.
REQ-017 IDLE, i_deal=1, o_cards_left>0: SHALL load probe index = lfsr[5:0], minus 52 if >=52, and go to SEARCH.
REQ-018 IDLE, i_deal=1, o_cards_left=0: SHALL pulse o_error next cycle, stay IDLE, leave all other state unchanged.
REQ-019 SEARCH: probe bit clear -> EMIT; probe bit set -> probe = probe+1, wrapping 51->0, stay SEARCH.
REQ-020 EMIT: SHALL set the probe's mask bit, decrement o_cards_left, pulse o_card_valid with o_card/o_rank/o_suit for the probe index, then return to IDLE.
REQ-021 o_card/o_rank/o_suit SHALL hold the last dealt card until the next EMIT.
REQ-022 o_card_valid SHALL assert no earlier than 2 and no later than 54 clocks after the edge accepting i_deal.
REQ-023 i_deal while busy SHALL be ignored, not queued.
REQ-024 i_shuffle SHALL, on the next edge in any state, clear the mask, set o_cards_left=52, go to IDLE, and suppress o_card_valid that cycle.
REQ-025 i_shuffle and i_deal on the same edge: shuffle SHALL win and the deal SHALL be dropped.
REQ-026 i_shuffle SHALL NOT reload the LFSR.
REQ-027 A card SHALL never be dealt twice between shuffles.

Reset
REQ-028 i_reset=1 SHALL immediately force: state IDLE, mask clear, o_cards_left=52, LFSR=SEED, o_card_valid=0, o_error=0, o_busy=0, o_card=0, o_rank=0, o_suit=0.
REQ-029 Reset asserted during SEARCH or EMIT SHALL abort the deal with no o_card_valid pulse and no mask bit set.
REQ-030 First deal SHALL be acceptable on the first rising edge after i_reset deasserts.

Verification
REQ-031 Reset, then observe outputs -> o_cards_left=52, o_busy=0, o_card=0, o_rank=0, o_suit=0, no pulses.
REQ-032 52 consecutive deals, each after o_busy falls -> 52 o_card_valid pulses, all (suit,rank) pairs distinct, o_cards_left counts 51..0, every valid within 54 clocks.
REQ-033 53rd deal on empty deck -> single o_error pulse, no o_card_valid, o_cards_left stays 0.
REQ-034 Deal 10 cards, then i_shuffle -> o_cards_left=52; then 52 more deals -> all distinct.
REQ-035 i_reset pulsed mid-SEARCH -> no o_card_valid, o_cards_left=52, o_busy=0; next deal completes normally.
REQ-036 Each dealt index decoded -> o_card correct: rank 1->1, rank 7->7, ranks 11/12/13->10.
